fc_mac_engine: RTL and testbench

Fully-connected output-layer engine for the MNIST classifier. It sits directly downstream of the weight memory bank and the image pixel buffer. It drives the shared dual read addresses and consumes two pixels plus two signed weights per class per cycle. It accumulates ten class scores over the 784 inputs, then runs a sequential argmax to produce the predicted digit.

---
 rtl/fc_pkg.sv | 20 ++
 rtl/fc_mac_lane.sv | 40 ++++
 rtl/fc_mac_engine.sv | 125 ++++++++++++
 tb/tb_fc_mac_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and widths for the fully-connected MNIST output layer.
// Lanes and the engine top import this package.
package fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam int NUM_CLASSES   = 10;
  localparam int PIX_W         = 8;
  localparam int WGT_W         = 8;
  localparam int PROD_W        = 17;
  localparam int PAIR_W        = 18;
  localparam int ACC_W_DEFAULT = 26;

endpackage

// File: rtl/fc_mac_lane.sv
// One class lane: two pixel*weight products, their pair sum, and a wrapping
// accumulator with synchronous clear and enable.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pixel1,
  input  logic [PIX_W-1:0]        pixel2,
  input  logic signed [WGT_W-1:0] w1,
  input  logic signed [WGT_W-1:0] w2,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod1, prod2;
  logic signed [PAIR_W-1:0] pair;
  logic signed [ACC_W-1:0]  acc_reg;

  // Pixels are unsigned, so a zero MSB makes them 9-bit signed operands.
  always_comb begin
    prod1 = PROD_W'($signed({1'b0, pixel1})) * PROD_W'(w1);
    prod2 = PROD_W'($signed({1'b0, pixel2})) * PROD_W'(w2);
    pair  = PAIR_W'(prod1) + PAIR_W'(prod2);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_W'(pair);
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/fc_mac_engine.sv
// Output-layer engine: streams input pairs through per-class MAC lanes,
// then scans the class scores sequentially to pick the argmax digit.
module fc_mac_engine
  import fc_pkg::*;
#(
  parameter int NC       = 9,
  parameter int N_INPUTS = 784,
  parameter int ACC_W    = ACC_W_DEFAULT,
  parameter int ADDR_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_W-1:0]       addr1,
  output logic [ADDR_W-1:0]       addr2,
  input  logic [PIX_W-1:0]        pixel1,
  input  logic [PIX_W-1:0]        pixel2,
  input  logic signed [WGT_W-1:0] weights [0:NC][0:1],
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] scores [0:NC],
  output logic [3:0]              class_out
);

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N_INPUTS / 2 - 1);
  localparam logic [3:0]        IDX_LAST = 4'(NC);

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       k_reg, addr1_reg, addr2_reg;
  logic                    valid_reg;
  logic [3:0]              idx_reg, best_idx_reg;
  logic signed [ACC_W-1:0] best_reg, cur_score;
  logic                    take, acc_clr;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_RUN;
      end
      S_RUN:    if (k_reg == K_LAST) state_next = S_DRAIN;
      S_DRAIN:  state_next = S_ARGMAX;
      S_ARGMAX: if (idx_reg == IDX_LAST) state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Ties keep the earlier index because only a strictly larger score wins.
  always_comb begin
    cur_score = scores[idx_reg];
    take      = (idx_reg == 4'd0) || (cur_score > best_reg);
    acc_clr   = (state_reg == S_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg        <= '0;
      addr1_reg    <= '0;
      addr2_reg    <= '0;
      valid_reg    <= 1'b0;
      idx_reg      <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      class_out    <= '0;
    end else begin
      valid_reg <= (state_reg == S_RUN);
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            k_reg     <= '0;
            addr1_reg <= '0;
            addr2_reg <= ADDR_W'(1);
            idx_reg   <= '0;
          end
        end
        S_RUN: begin
          if (k_reg != K_LAST) begin
            k_reg     <= k_reg + ADDR_W'(1);
            addr1_reg <= addr1_reg + ADDR_W'(2);
            addr2_reg <= addr2_reg + ADDR_W'(2);
          end
        end
        S_ARGMAX: begin
          idx_reg <= idx_reg + 4'd1;
          if (take) begin
            best_reg     <= cur_score;
            best_idx_reg <= idx_reg;
          end
          if (idx_reg == IDX_LAST) class_out <= take ? idx_reg : best_idx_reg;
        end
        default: ;
      endcase
    end
  end

  assign addr1 = addr1_reg;
  assign addr2 = addr2_reg;

  for (genvar gi = 0; gi <= NC; gi++) begin : g_lane
    fc_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .en     (valid_reg),
      .pixel1 (pixel1),
      .pixel2 (pixel2),
      .w1     (weights[gi][0]),
      .w2     (weights[gi][1]),
      .acc    (scores[gi])
    );
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// Bench for fc_mac_engine: emulated pixel/weight memories, a dot-product
// reference model, and cycle-by-cycle checks of every inference.
module tb_fc_mac_engine;

  localparam int NC     = 9;
  localparam int NIN    = 784;
  localparam int ACC_W  = 26;
  localparam int ADDR_W = 10;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [ADDR_W-1:0]       addr1, addr2;
  logic [7:0]              pixel1, pixel2;
  logic signed [7:0]       weights [0:NC][0:1];
  logic                    busy, done;
  logic signed [ACC_W-1:0] scores [0:NC];
  logic [3:0]              class_out;

  logic [7:0]        pmem [0:1023];
  logic signed [7:0] wmem [0:1023][0:NC];

  int errors = 0;
  int checks = 0;

  longint exp_s [0:NC];
  int     exp_cls;

  always #5 clk = ~clk;

  fc_mac_engine #(.NC(NC), .N_INPUTS(NIN), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr1     (addr1),
    .addr2     (addr2),
    .pixel1    (pixel1),
    .pixel2    (pixel2),
    .weights   (weights),
    .busy      (busy),
    .done      (done),
    .scores    (scores),
    .class_out (class_out)
  );

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    pixel1 <= pmem[addr1];
    pixel2 <= pmem[addr2];
    for (int c = 0; c <= NC; c++) begin
      weights[c][0] <= wmem[addr1][c];
      weights[c][1] <= wmem[addr2][c];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pmode, input int wmode);
    for (int n = 0; n < 1024; n++) begin
      case (pmode)
        0:       pmem[n] = 8'd0;
        1:       pmem[n] = 8'd1;
        2:       pmem[n] = 8'd255;
        default: pmem[n] = 8'($urandom);
      endcase
      for (int c = 0; c <= NC; c++) begin
        case (wmode)
          1:       wmem[n][c] = 8'(c);
          2:       wmem[n][c] = -8'sd128;
          3:       wmem[n][c] = (c == 3 || c == 7) ? 8'sd2 : 8'sd1;
          default: wmem[n][c] = 8'($urandom);
        endcase
      end
    end
  endtask

  // Plain dot product per class, wrapped to the accumulator width, then argmax.
  task automatic model();
    longint sum;
    logic signed [ACC_W-1:0] t;
    for (int c = 0; c <= NC; c++) begin
      sum = 0;
      for (int n = 0; n < NIN; n++) sum += longint'(pmem[n]) * longint'(wmem[n][c]);
      t = sum[ACC_W-1:0];
      exp_s[c] = longint'(t);
    end
    exp_cls = 0;
    for (int c = 1; c <= NC; c++) if (exp_s[c] > exp_s[exp_cls]) exp_cls = c;
  endtask

  task automatic run_check(input string name, input int nruns, input bit hold,
                           input int lit_idx, input longint lit_score, input int lit_cls);
    int dones;
    model();
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int r = 0; r < nruns; r++) begin
      for (int t = 1; t <= 405; t++) begin
        @(negedge clk);
        if (!hold && t == 1) start = 1'b0;
        chk({name, " busy"}, longint'(busy), longint'(t <= 404));
        chk({name, " done"}, longint'(done), longint'(t == 404));
        if (done) dones++;
        if (t <= 392) begin
          chk({name, " addr1"}, longint'(addr1), longint'(2 * (t - 1)));
          chk({name, " addr2"}, longint'(addr2), longint'(2 * (t - 1) + 1));
        end else begin
          chk({name, " addr1 hold"}, longint'(addr1), 782);
          chk({name, " addr2 hold"}, longint'(addr2), 783);
        end
        if (t >= 404) begin
          for (int c = 0; c <= NC; c++)
            chk($sformatf("%s score[%0d]", name, c), longint'(scores[c]), exp_s[c]);
          chk({name, " class_out"}, longint'(class_out), longint'(exp_cls));
          if (lit_idx >= 0) begin
            chk({name, " literal score"}, longint'(scores[lit_idx]), lit_score);
            chk({name, " literal class"}, longint'(class_out), longint'(lit_cls));
          end
        end
        if (hold && r == nruns - 1 && t == 405) start = 1'b0;
      end
    end
    chk({name, " done count"}, longint'(dones), longint'(nruns));
    $display("run %s: class_out=%0d expected=%0d score0=%0d", name, class_out, exp_cls,
             scores[0]);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset addr1", longint'(addr1), 0);
    chk("reset addr2", longint'(addr2), 0);
    chk("reset class_out", longint'(class_out), 0);
    for (int c = 0; c <= NC; c++) chk($sformatf("reset score[%0d]", c), longint'(scores[c]), 0);

    fill(0, 0);
    run_check("zero_pixels", 1, 1'b0, 0, 0, 0);
    fill(1, 1);
    run_check("ramp_weights", 1, 1'b0, 9, 7056, 9);
    fill(2, 2);
    run_check("max_negative", 1, 1'b0, 5, -25589760, 0);
    fill(1, 3);
    run_check("tie_3_7", 1, 1'b0, 7, 1568, 3);
    fill(3, 0);
    run_check("random_a", 1, 1'b0, -1, 0, 0);

    // Abort a run at k=100 with reset, then repeat on a clean random image.
    fill(3, 0);
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 101; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (done) chk("abort early done", longint'(done), 0);
    end
    chk("abort addr1 at k=100", longint'(addr1), 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", longint'(busy), 0);
    chk("abort addr1", longint'(addr1), 0);
    chk("abort addr2", longint'(addr2), 0);
    chk("abort class_out", longint'(class_out), 0);
    for (int c = 0; c <= NC; c++) chk($sformatf("abort score[%0d]", c), longint'(scores[c]), 0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("abort no done", longint'(done), 0);
    end
    run_check("after_abort", 1, 1'b0, -1, 0, 0);

    fill(1, 1);
    run_check("start_held", 2, 1'b1, 4, 3136, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
